instr_prefetch: RTL and testbench

//  Instruction fetch stage directly upstream of the 17-bit single-cycle datapath.

---
 rtl/instr_prefetch.sv | 139 +++++++++++++
 tb/tb_instr_prefetch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher: one outstanding req/ack fetch, DEPTH-entry queue, redirect flush.
// Define INSTR_PREFETCH_BYPASS_EN for a zero-latency ack-to-issue path when the queue is empty.
module instr_prefetch #(
  parameter int DATA_W   = 17,
  parameter int ADDR_W   = 17,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_ack,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic                       instr_valid,
  output logic [DATA_W-1:0]          instr,
  output logic [ADDR_W-1:0]          instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] START = ADDR_W'(RESET_PC);

  typedef enum logic {FETCH, DISCARD} state_t;
  state_t state_reg, state_next;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next, addr_reg, addr_next;
  logic              req_reg, req_next;
  logic              fire, hold, push, pop, bypass;

  assign fire = req_reg & imem_ack;
  assign hold = req_reg & ~imem_ack;

`ifdef INSTR_PREFETCH_BYPASS_EN
  assign bypass = fire & (count_reg == '0) & (state_reg == FETCH) & ~redirect;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that the datapath accepts never enters the queue.
  assign push = fire & (state_reg == FETCH) & ~redirect & ~(bypass & instr_ready);
  assign pop  = (count_reg != '0) & instr_ready;

  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;
  assign count     = count_reg;

  always_comb begin
    instr_valid = 1'b0;
    instr       = '0;
    instr_pc    = '0;
    if (count_reg != '0) begin
      instr_valid = 1'b1;
      instr       = data_mem[rd_ptr_reg];
      instr_pc    = pc_mem[rd_ptr_reg];
    end else if (bypass) begin
      instr_valid = 1'b1;
      instr       = imem_rdata;
      instr_pc    = addr_reg;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    fetch_pc_next = fetch_pc_reg;
    addr_next     = addr_reg;
    req_next      = req_reg;

    if (redirect) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
      fetch_pc_next = redirect_pc;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end

    case (state_reg)
      FETCH: begin
        if (fire && !redirect) fetch_pc_next = fetch_pc_reg + STEP;
        if (hold && redirect)  state_next = DISCARD;
      end
      DISCARD: begin
        if (imem_ack) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // Space is reserved when the request is raised, so a full queue never overflows.
    if (!hold) begin
      req_next  = (count_next < FULL);
      addr_next = fetch_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= FETCH;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      fetch_pc_reg <= START;
      addr_reg     <= START;
      req_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      fetch_pc_reg <= fetch_pc_next;
      addr_reg     <= addr_next;
      req_reg      <= req_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]   <= addr_reg;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: cycle table for streaming/backpressure, hand sequences for
// redirect, discard, wrap, reset-mid-request and the optional bypass path.
module tb_instr_prefetch;
  logic        clk = 1'b0;
  logic        reset, redirect, imem_ack, instr_ready;
  logic [16:0] redirect_pc, imem_rdata;
  logic        imem_req, instr_valid;
  logic [16:0] imem_addr, instr, instr_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  instr_prefetch dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        ack;
    logic [16:0] rdata;
    logic        ready;
    logic        exp_req;
    logic [16:0] exp_addr;
    logic        exp_valid;
    logic [16:0] exp_instr;
    logic [16:0] exp_pc;
    logic [2:0]  exp_count;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ack, input logic [16:0] rdata,
                              input logic ready, input logic er, input logic [16:0] ea,
                              input logic ev, input logic [16:0] ei, input logic [16:0] ep,
                              input logic [2:0] ec);
    vec_t v;
    v = '{rst, ack, rdata, ready, er, ea, ev, ei, ep, ec};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic redir, input logic [16:0] rpc,
                       input logic ack, input logic [16:0] rdata, input logic ready);
    reset       = rst;
    redirect    = redir;
    redirect_pc = rpc;
    imem_ack    = ack;
    imem_rdata  = rdata;
    instr_ready = ready;
  endtask

  // Compare outputs mid-cycle, then advance to just after the next rising edge.
  task automatic look(input string tag, input logic er, input logic [16:0] ea, input logic ev,
                      input logic [16:0] ei, input logic [16:0] ep, input logic [2:0] ec);
    #2;
    chk({tag, ".req"}, 32'(imem_req), 32'(er));
    if (er) chk({tag, ".addr"}, 32'(imem_addr), 32'(ea));
    chk({tag, ".valid"}, 32'(instr_valid), 32'(ev));
    chk({tag, ".instr"}, 32'(instr), 32'(ei));
    chk({tag, ".pc"}, 32'(instr_pc), 32'(ep));
    chk({tag, ".count"}, 32'(count), 32'(ec));
    $display("%-12s req=%0d addr=%05h valid=%0d instr=%05h pc=%05h count=%0d",
             tag, imem_req, imem_addr, instr_valid, instr, instr_pc, count);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [20];

  initial begin
    drive(1'b1, 1'b0, 17'h0, 1'b0, 17'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

`ifndef INSTR_PREFETCH_BYPASS_EN
    //            rst ack rdata     rdy  req addr     vld instr     pc       cnt
    vecs[0]  = mk(1, 0, 17'h00000, 1,   0, 17'h000, 0, 17'h00000, 17'h000, 0);
    vecs[1]  = mk(0, 0, 17'h00000, 1,   0, 17'h000, 0, 17'h00000, 17'h000, 0);
    vecs[2]  = mk(0, 1, 17'h00100, 1,   1, 17'h000, 0, 17'h00000, 17'h000, 0);
    vecs[3]  = mk(0, 1, 17'h00104, 1,   1, 17'h004, 1, 17'h00100, 17'h000, 1);
    vecs[4]  = mk(0, 1, 17'h00108, 1,   1, 17'h008, 1, 17'h00104, 17'h004, 1);
    vecs[5]  = mk(0, 0, 17'h00000, 1,   1, 17'h00C, 1, 17'h00108, 17'h008, 1);
    vecs[6]  = mk(1, 0, 17'h00000, 0,   1, 17'h00C, 0, 17'h00000, 17'h000, 0);
    vecs[7]  = mk(0, 0, 17'h00000, 0,   0, 17'h000, 0, 17'h00000, 17'h000, 0);
    vecs[8]  = mk(0, 1, 17'h00200, 0,   1, 17'h000, 0, 17'h00000, 17'h000, 0);
    vecs[9]  = mk(0, 1, 17'h00204, 0,   1, 17'h004, 1, 17'h00200, 17'h000, 1);
    vecs[10] = mk(0, 1, 17'h00208, 0,   1, 17'h008, 1, 17'h00200, 17'h000, 2);
    vecs[11] = mk(0, 1, 17'h0020C, 0,   1, 17'h00C, 1, 17'h00200, 17'h000, 3);
    vecs[12] = mk(0, 1, 17'h00000, 0,   0, 17'h000, 1, 17'h00200, 17'h000, 4);
    vecs[13] = mk(0, 0, 17'h00000, 1,   0, 17'h000, 1, 17'h00200, 17'h000, 4);
    vecs[14] = mk(0, 0, 17'h00000, 1,   1, 17'h010, 1, 17'h00204, 17'h004, 3);
    vecs[15] = mk(0, 0, 17'h00000, 1,   1, 17'h010, 1, 17'h00208, 17'h008, 2);
    vecs[16] = mk(0, 0, 17'h00000, 1,   1, 17'h010, 1, 17'h0020C, 17'h00C, 1);
    vecs[17] = mk(0, 1, 17'h00210, 1,   1, 17'h010, 0, 17'h00000, 17'h000, 0);
    vecs[18] = mk(0, 0, 17'h00000, 1,   1, 17'h014, 1, 17'h00210, 17'h010, 1);
    vecs[19] = mk(0, 0, 17'h00000, 0,   1, 17'h014, 0, 17'h00000, 17'h000, 0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, 1'b0, 17'h0, vecs[i].ack, vecs[i].rdata, vecs[i].ready);
      look($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valid,
           vecs[i].exp_instr, vecs[i].exp_pc, vecs[i].exp_count);
    end

    // Delayed ack with redirect during the wait: old word dropped, then fetch at 0x100.
    drive(1, 0, 17'h0, 0, 17'h0, 0);         look("t3_rst", 1, 17'h014, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 0, 17'h0, 0);         look("t3_rel", 0, 17'h000, 0, 0, 0, 0);
    drive(0, 1, 17'h100, 0, 17'h0, 0);       look("t3_w1", 1, 17'h000, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 0, 17'h0, 0);         look("t3_w2", 1, 17'h000, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 0, 17'h0, 0);         look("t3_w3", 1, 17'h000, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 1, 17'h1DEAD, 0);     look("t3_ackold", 1, 17'h000, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 0, 17'h0, 0);         look("t3_new", 1, 17'h100, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 1, 17'h0BEEF, 0);     look("t3_acknew", 1, 17'h100, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 0, 17'h0, 0);         look("t3_out", 1, 17'h104, 1, 17'h0BEEF, 17'h100, 1);

    // count=2 then redirect + ack + pop together.
    drive(0, 0, 17'h0, 1, 17'h00111, 0);     look("t4_fill", 1, 17'h104, 1, 17'h0BEEF, 17'h100, 1);
    drive(0, 1, 17'h200, 1, 17'h00222, 1);   look("t4_redir", 1, 17'h108, 1, 17'h0BEEF, 17'h100, 2);
    drive(0, 0, 17'h0, 0, 17'h0, 1);         look("t4_after", 1, 17'h200, 0, 0, 0, 0);

    // Fetch address wrap at the top of the address space.
    drive(0, 1, 17'h1FFFC, 1, 17'h00333, 1); look("t5_redir", 1, 17'h200, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 1, 17'h00AAA, 1);     look("t5_top", 1, 17'h1FFFC, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 1, 17'h00BBB, 1);     look("t5_wrap", 1, 17'h00000, 1, 17'h00AAA, 17'h1FFFC, 1);
    drive(0, 0, 17'h0, 0, 17'h0, 1);         look("t5_next", 1, 17'h00004, 1, 17'h00BBB, 17'h00000, 1);

    // Reset while a request is outstanding.
    drive(1, 0, 17'h0, 0, 17'h0, 0);         look("t6_pre", 1, 17'h004, 0, 0, 0, 0);
    drive(1, 0, 17'h0, 0, 17'h0, 0);         look("t6_inrst", 0, 17'h000, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 0, 17'h0, 0);         look("t6_rel", 0, 17'h000, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 0, 17'h0, 0);         look("t6_fetch", 1, 17'h000, 0, 0, 0, 0);

    // A second redirect while discarding only retargets the restart address.
    drive(0, 1, 17'h040, 0, 17'h0, 0);       look("x_r1", 1, 17'h000, 0, 0, 0, 0);
    drive(0, 1, 17'h080, 0, 17'h0, 0);       look("x_r2", 1, 17'h000, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 1, 17'h00001, 0);     look("x_ack", 1, 17'h000, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 0, 17'h0, 0);         look("x_new", 1, 17'h080, 0, 0, 0, 0);

    // Without bypass the acked word appears one cycle later via the queue.
    drive(0, 0, 17'h0, 1, 17'h1ABCD, 1);     look("t7_nobyp", 1, 17'h080, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 0, 17'h0, 0);         look("t7_next", 1, 17'h084, 1, 17'h1ABCD, 17'h080, 1);
`else
    drive(1, 0, 17'h0, 0, 17'h0, 0);         look("b_rst", 0, 17'h000, 0, 0, 0, 0);
    drive(0, 0, 17'h0, 0, 17'h0, 0);         look("b_rel", 0, 17'h000, 0, 0, 0, 0);
    // Empty queue: acked word issues in the same cycle and is consumed.
    drive(0, 0, 17'h0, 1, 17'h1ABCD, 1);     look("t7_byp", 1, 17'h000, 1, 17'h1ABCD, 17'h000, 0);
    // Not ready: word shows combinationally and is also pushed.
    drive(0, 0, 17'h0, 1, 17'h05555, 0);     look("t7_hold", 1, 17'h004, 1, 17'h05555, 17'h004, 0);
    drive(0, 0, 17'h0, 0, 17'h0, 0);         look("t7_q", 1, 17'h008, 1, 17'h05555, 17'h004, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
